// File: rtl/regbank_exec_seq.sv
// Multi-cycle execute sequencer mastering the 4x32 register bank: read, execute, write back.
// Optional iterative multiplier for op 7 is compiled in with `define ALU_MUL_EN.
module regbank_exec_seq #(
    parameter int DW = 32,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    op_code,
    input  logic [AW-1:0] op_rd,
    input  logic [AW-1:0] op_rs1,
    input  logic [AW-1:0] op_rs2,
    output logic [AW-1:0] ra1,
    output logic [AW-1:0] ra2,
    input  logic [DW-1:0] rdata1,
    input  logic [DW-1:0] rdata2,
    output logic          write,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wdata,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
`ifdef ALU_MUL_EN
        , S_MUL
`endif
    } state_t;

    state_t        state;
    logic [2:0]    code_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] opa, opb;
    logic [DW-1:0] alu_res;
    logic          alu_err;

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(DW);
    logic [DW-1:0] acc, acc_next;
    logic [CW-1:0] cnt;

    // opa doubles as the shifted multiplicand and opb as the shifted multiplier
    assign acc_next = acc + (opb[0] ? opa : '0);
`endif

    assign op_ready = (state == S_IDLE);

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (code_q)
            3'd0:    alu_res = opa + opb;
            3'd1:    alu_res = opa - opb;
            3'd2:    alu_res = opa & opb;
            3'd3:    alu_res = opa | opb;
            3'd4:    alu_res = opa ^ opb;
            3'd5:    alu_res = opa << opb[4:0];
            3'd6:    alu_res = opa >> opb[4:0];
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            code_q <= '0;
            rd_q   <= '0;
            ra1    <= '0;
            ra2    <= '0;
            opa    <= '0;
            opb    <= '0;
            write  <= 1'b0;
            wa     <= '0;
            wdata  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
`ifdef ALU_MUL_EN
            acc    <= '0;
            cnt    <= '0;
`endif
        end else begin
            // strobes are single-cycle; wa/wdata hold outside WB
            write <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        code_q <= op_code;
                        rd_q   <= op_rd;
                        ra1    <= op_rs1;
                        ra2    <= op_rs2;
                        state  <= S_READ;
                    end
                end
                S_READ: begin
                    opa   <= rdata1;
                    opb   <= rdata2;
                    state <= S_EXEC;
                end
                S_EXEC: begin
`ifdef ALU_MUL_EN
                    if (code_q == 3'd7) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_MUL;
                    end else
`endif
                    begin
                        write <= 1'b1;
                        wa    <= rd_q;
                        wdata <= alu_res;
                        done  <= 1'b1;
                        err   <= alu_err;
                        state <= S_WB;
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    acc <= acc_next;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DW - 1)) begin
                        write <= 1'b1;
                        wa    <= rd_q;
                        wdata <= acc_next;
                        done  <= 1'b1;
                        state <= S_WB;
                    end
                end
`endif
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_exec_seq.sv
// Directed bench for regbank_exec_seq with a behavioural 4x32 register bank attached.
module tb_regbank_exec_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [1:0]  op_rd, op_rs1, op_rs2;
    logic [1:0]  ra1, ra2, wa;
    logic [31:0] rdata1, rdata2, wdata;
    logic        write, done, err;

    logic [31:0] bank [4];
    logic        pl_en;
    logic [1:0]  pl_addr;
    logic [31:0] pl_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regbank_exec_seq #(.DW(32), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_rd(op_rd), .op_rs1(op_rs1), .op_rs2(op_rs2),
        .ra1(ra1), .ra2(ra2), .rdata1(rdata1), .rdata2(rdata2),
        .write(write), .wa(wa), .wdata(wdata), .done(done), .err(err)
    );

    assign rdata1 = bank[ra1];
    assign rdata2 = bank[ra2];

    always @(posedge clk) begin
        if (pl_en)      bank[pl_addr] <= pl_data;
        else if (write) bank[wa] <= wdata;
    end

    task automatic preload(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one op and reports what the write cycle looked like; wcyc=-1 if no write in 60 cycles
    task automatic run_op(input logic [2:0] c, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, output int wcyc, output logic [31:0] wd,
                          output logic [1:0] wad, output logic dn, output logic er,
                          output logic busy);
        @(negedge clk);
        op_valid = 1'b1; op_code = c; op_rd = rd; op_rs1 = rs1; op_rs2 = rs2;
        @(posedge clk);
        #1 op_valid = 1'b0;
        wcyc = -1; wd = '0; wad = '0; dn = 1'b0; er = 1'b0; busy = 1'b1;
        for (int cy = 1; cy <= 60; cy++) begin
            @(negedge clk);
            if (op_ready) busy = 1'b0;
            if (write) begin
                wcyc = cy; wd = wdata; wad = wa; dn = done; er = err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        op_valid = 1'b1; op_code = 3'd0; op_rd = 2'd3; op_rs1 = 2'd3; op_rs2 = 2'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (op_ready !== 1'b1 || write !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: ready=%b write=%b done=%b err=%b, want 1 0 0 0",
                     op_ready, write, done, err);
        end
        tests++;
        if (wa !== 2'd0 || wdata !== 32'd0 || ra1 !== 2'd0 || ra2 !== 2'd0) begin
            fails++;
            $display("FAIL reset_data: wa=%0d wdata=%h ra1=%0d ra2=%0d, want all 0",
                     wa, wdata, ra1, ra2);
        end
        op_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (op_ready !== 1'b1 || write !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ready=%b write=%b, want 1 0", op_ready, write);
        end
    endtask

    task automatic test_add;
        int wc; logic [31:0] wd; logic [1:0] wad; logic dn, er, busy;
        preload(2'd1, 32'h0000_0005);
        preload(2'd2, 32'h0000_0003);
        run_op(3'd0, 2'd0, 2'd1, 2'd2, wc, wd, wad, dn, er, busy);
        tests++;
        if (wc !== 3) begin
            fails++; $display("FAIL add_latency: write cycle %0d, want 3", wc);
        end
        tests++;
        if (wd !== 32'h8 || wad !== 2'd0) begin
            fails++; $display("FAIL add_data: wdata=%h wa=%0d, want 00000008 0", wd, wad);
        end
        tests++;
        if (dn !== 1'b1 || er !== 1'b0) begin
            fails++; $display("FAIL add_flags: done=%b err=%b, want 1 0", dn, er);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL add_busy: op_ready seen high in cycles 1-3, want low");
        end
        @(negedge clk);
        tests++;
        if (op_ready !== 1'b1 || write !== 1'b0 || bank[0] !== 32'h8) begin
            fails++;
            $display("FAIL add_after: ready=%b write=%b r0=%h, want 1 0 00000008",
                     op_ready, write, bank[0]);
        end
    endtask

    task automatic test_alu;
        logic [2:0]  t_code [6] = '{3'd1, 3'd5, 3'd6, 3'd2, 3'd3, 3'd5};
        logic [1:0]  t_rd   [6] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [1:0]  t_rs1  [6] = '{2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};
        logic [1:0]  t_rs2  [6] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2};
        logic        t_pre  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] t_prd  [6] = '{32'h0, 32'h24, 32'h0, 32'h0, 32'h0, 32'h20};
        logic [31:0] t_exp  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFE0, 32'h0FFF_FFFE,
                                    32'h0000_0004, 32'h0000_0024, 32'h0000_0005};
        int wc; logic [31:0] wd; logic [1:0] wad; logic dn, er, busy;
        for (int i = 0; i < 6; i++) begin
            if (t_pre[i]) preload(2'd2, t_prd[i]);
            run_op(t_code[i], t_rd[i], t_rs1[i], t_rs2[i], wc, wd, wad, dn, er, busy);
            tests++;
            if (wc !== 3 || wd !== t_exp[i] || wad !== t_rd[i] || dn !== 1'b1 || er !== 1'b0) begin
                fails++;
                $display("FAIL alu_op%0d: cyc=%0d wdata=%h wa=%0d done=%b err=%b, want 3 %h %0d 1 0",
                         i, wc, wd, wad, dn, er, t_exp[i], t_rd[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int          cyc [2] = '{-1, -1};
        logic [31:0] dat [2] = '{32'h0, 32'h0};
        logic [1:0]  adr [2] = '{2'd0, 2'd0};
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd0; op_rd = 2'd1; op_rs1 = 2'd1; op_rs2 = 2'd1;
        @(posedge clk);
        #1 op_code = 3'd4; op_rd = 2'd2;
        for (int cy = 1; cy <= 14; cy++) begin
            @(negedge clk);
            if (cy == 5) op_valid = 1'b0;
            if (write) begin
                if (n < 2) begin cyc[n] = cy; dat[n] = wdata; adr[n] = wa; end
                n++;
            end
        end
        tests++;
        if (n !== 2) begin
            fails++; $display("FAIL b2b_count: %0d writes, want 2", n);
        end
        tests++;
        if (cyc[0] !== 3 || dat[0] !== 32'hA || adr[0] !== 2'd1) begin
            fails++;
            $display("FAIL b2b_first: cyc=%0d wdata=%h wa=%0d, want 3 0000000a 1", cyc[0], dat[0], adr[0]);
        end
        tests++;
        if (cyc[1] !== 7 || dat[1] !== 32'h0 || adr[1] !== 2'd2) begin
            fails++;
            $display("FAIL b2b_second: cyc=%0d wdata=%h wa=%0d, want 7 00000000 2", cyc[1], dat[1], adr[1]);
        end
    endtask

    task automatic test_mul;
        int wc; logic [31:0] wd; logic [1:0] wad; logic dn, er, busy;
`ifdef ALU_MUL_EN
        int          e_cyc = 35;
        logic [31:0] e_dat = 32'hFFFF_FFFE;
        logic        e_err = 1'b0;
`else
        int          e_cyc = 3;
        logic [31:0] e_dat = 32'h0;
        logic        e_err = 1'b1;
`endif
        preload(2'd1, 32'hFFFF_FFFF);
        preload(2'd2, 32'h0000_0002);
        run_op(3'd7, 2'd0, 2'd1, 2'd2, wc, wd, wad, dn, er, busy);
        tests++;
        if (wc !== e_cyc) begin
            fails++; $display("FAIL mul_latency: write cycle %0d, want %0d", wc, e_cyc);
        end
        tests++;
        if (wd !== e_dat || wad !== 2'd0 || dn !== 1'b1 || er !== e_err) begin
            fails++;
            $display("FAIL mul_result: wdata=%h wa=%0d done=%b err=%b, want %h 0 1 %b",
                     wd, wad, dn, er, e_dat, e_err);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL mul_busy: op_ready seen high before write");
        end
    endtask

    task automatic test_reset_mid(input logic [2:0] c, input int at_cyc);
        logic seen = 1'b0;
        preload(2'd3, 32'h1234_5678);
        @(negedge clk);
        op_valid = 1'b1; op_code = c; op_rd = 2'd3; op_rs1 = 2'd1; op_rs2 = 2'd2;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (at_cyc) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if (write !== 1'b0 || done !== 1'b0 || err !== 1'b0 || wdata !== 32'h0 ||
            wa !== 2'd0 || ra1 !== 2'd0 || ra2 !== 2'd0 || op_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid%0d_outputs: write=%b done=%b err=%b wdata=%h wa=%0d ra1=%0d ra2=%0d ready=%b, want zeros ready=1",
                     c, write, done, err, wdata, wa, ra1, ra2, op_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (write || done) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0 || op_ready !== 1'b1) begin
            fails++; $display("FAIL rstmid%0d_quiet: write/done seen=%b ready=%b, want 0 1", c, seen, op_ready);
        end
        tests++;
        if (bank[3] !== 32'h1234_5678) begin
            fails++; $display("FAIL rstmid%0d_reg: r3=%h, want 12345678", c, bank[3]);
        end
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = '0; op_rd = '0; op_rs1 = '0; op_rs2 = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        test_reset;
        test_add;
        test_alu;
        test_back_to_back;
        test_mul;
        test_reset_mid(3'd0, 2);
`ifdef ALU_MUL_EN
        test_reset_mid(3'd7, 10);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regbank_exec_seq.md
Name: regbank_exec_seq

Overview:
- Multi-cycle execute sequencer directly downstream of the 4x32 register bank.
- Accepts one register-to-register operation at a time over a valid/ready handshake.
- Drives the bank read addresses, captures both operands, computes a 32-bit result, and writes it back through the bank write port.
- Acts as the bank's only master; one operation in flight, no overlap.

Parameters:
- DW, 32, datapath width; must match bank data width.
- AW, 2, register address width (4 registers).

Ports:
- clk  in  1  rising-edge clock, shared with register bank
- rst  in  1  asynchronous active-high reset
- op_valid  in  1  operation request valid
- op_ready  out  1  sequencer can accept (high only in IDLE)
- op_code  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL
- op_rd  in  AW  destination register
- op_rs1  in  AW  source register A
- op_rs2  in  AW  source register B
- ra1  out  AW  to bank ra1
- ra2  out  AW  to bank ra2
- rdata1  in  DW  from bank rdata1 (combinational read)
- rdata2  in  DW  from bank rdata2
- write  out  1  to bank write
- wa  out  AW  to bank wa
- wdata  out  DW  to bank wdata
- done  out  1  one-cycle pulse coincident with write
- err  out  1  one-cycle pulse with done on an unsupported opcode

Behaviour:
- Reset: async, active-high. While rst is high: state=IDLE and all registered outputs are 0 (write, wa, wdata, done, err, ra1, ra2, internal operand/result regs). op_ready=1 once state=IDLE, but requests are ignored while rst is high.
- Reset mid-operation: the in-flight op is discarded and no write is issued. write drops immediately (asynchronously).
- States: IDLE, READ, EXEC, MUL (ALU_MUL_EN only), WB.
- IDLE:
  - op_ready=1.
  - On op_valid&&op_ready at edge E0: latch op_code/rd/rs1/rs2; ra1<=rs1, ra2<=rs2; go to READ.
- READ (cycle after E0):
  - ra1/ra2 are stable.
  - At the closing edge, capture opa<=rdata1, opb<=rdata2; go to EXEC.
- EXEC:
  - Compute the result from opa/opb. Go to WB, or to MUL for op 7 when the feature is enabled.
  - Arithmetic is modulo 2^DW; carries/borrows are dropped. SUB = opa-opb.
  - SLL/SRL: shift amount opb[4:0], logical, zero fill. Amount 0 gives opa.
- WB (exactly one cycle):
  - write=1, wa=rd, wdata=result, done=1. err=1 if the opcode is unsupported.
  - Bank commits at the closing edge; next state IDLE.
- Latency and throughput:
  - Single-cycle ops: accept edge E0; write/done high during cycle 3; op_ready high again in cycle 4.
  - Throughput 1 op per 4 cycles.
- write, wa, wdata, done and err are registered. write=0 in every state except WB. wa/wdata hold their last values outside WB.
- Hazards: rd may equal rs1/rs2. A back-to-back op reading rd sees the new value, because the write commits before the next READ. No forwarding is needed.
- op_valid held high across a busy period is not consumed until IDLE. Fields are sampled only at the accept edge; changing them while not ready has no effect.

Optional Feature:
- Macro: ALU_MUL_EN
- Defined:
  - op 7 enters MUL: iterative shift-add, one multiplier bit per cycle, DW cycles, low DW bits of the product kept.
  - Then WB with err=0. Op 7 latency = 3+DW cycles from accept to write (write in cycle 35 for DW=32).
  - Reset during MUL aborts it; no write.
- Not defined:
  - MUL state and multiplier logic are absent.
  - op 7 follows the single-cycle path: WB with write=1, wdata=0, err=1.

Test Plan:
- Preload r1=0x0000_0005, r2=0x0000_0003; ADD rd=0 rs1=1 rs2=2 -> write in cycle 3, wa=0, wdata=0x8, done=1, err=0; op_ready=0 in cycles 1-3.
- SUB rd=3 rs1=2 rs2=1 with r2=3, r1=5 -> wdata=0xFFFF_FFFE. Then SLL rd=3 rs1=3 rs2=2 with r2=0x24 -> shift by 4 -> wdata=0xFFFF_FFE0.
- Back-to-back with op_valid held high: ADD rd=1 rs1=1 rs2=1 (r1=5) then XOR rd=2 rs1=1 rs2=1 -> first wdata=0xA, second reads 0xA -> wdata=0x0. Writes exactly 4 cycles apart.
- MUL rs1=0xFFFF_FFFF, rs2=0x2:
  - With ALU_MUL_EN -> write at cycle 35, wdata=0xFFFF_FFFE, err=0.
  - Without -> write at cycle 3, wdata=0, err=1.
- Assert rst during EXEC (or mid-MUL) -> write stays 0, no done pulse, outputs 0, op_ready=1 after release, target register unchanged.
